// File: rtl/f_fetch_unit_if.sv
// rtl/f_fetch_unit_if.sv - instruction-memory request/grant/rvalid bus
interface f_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/f_fetch_unit.sv
// rtl/f_fetch_unit.sv - IF stage: PC_F, imem sequencing and F/D pipeline register
module f_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic                  clk,
    input  logic                  reset,
    f_fetch_unit_if.master        imem,
    input  logic [31:0]           npc_f,
    input  logic                  stall_d,
    output logic [31:0]           pc_f,
    output logic [31:0]           instr_d,
    output logic [31:0]           pc_d,
    output logic [31:0]           pc8_d,
    output logic                  valid_d
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] buf_q;
    logic [31:0] tgt_q;
    logic        tgt_held;
    logic        data_ok;
    logic [31:0] data;
    logic        xfer;
    logic        bubble;
    logic        buf_load;

    always_comb begin
        state_d  = state_q;
        data_ok  = 1'b0;
        data     = buf_q;
        buf_load = 1'b0;
        case (state_q)
            S_REQ: begin
                if (imem.imem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    data_ok = 1'b1;
                    data    = imem.imem_rdata;
                    if (stall_d) begin
                        buf_load = 1'b1;
                        state_d  = S_HOLD;
                    end else begin
                        state_d  = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                data_ok = 1'b1;
                if (!stall_d) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    assign xfer           = data_ok && !stall_d;
    assign bubble         = !data_ok && !stall_d;
    assign imem.imem_req  = (state_q == S_REQ);
    assign imem.imem_addr = {pc_f[31:2], 2'b00};
    assign pc8_d          = pc_d + 32'd8;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_REQ;
            pc_f     <= RESET_PC;
            instr_d  <= 32'd0;
            pc_d     <= 32'd0;
            valid_d  <= 1'b0;
            buf_q    <= 32'd0;
            tgt_q    <= 32'd0;
            tgt_held <= 1'b0;
        end else begin
            state_q <= state_d;
            if (buf_load) buf_q <= imem.imem_rdata;
            if (xfer) begin
                instr_d  <= data;
                pc_d     <= pc_f;
                valid_d  <= 1'b1;
                pc_f     <= tgt_held ? tgt_q : npc_f;
                tgt_held <= 1'b0;
            end else if (bubble) begin
                instr_d <= 32'd0;
                pc_d    <= pc_f;
                valid_d <= 1'b0;
                // The D instruction is leaving before its delay slot arrives,
                // so npc_f will stop reflecting it; keep its redirect now.
                if (valid_d && !tgt_held) begin
                    tgt_q    <= npc_f;
                    tgt_held <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_f_fetch_unit.sv
// tb/tb_f_fetch_unit.sv - self-checking bench for f_fetch_unit
module tb_f_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        stall_d;
    logic [31:0] npc_f;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc8_d;
    logic        valid_d;

    f_fetch_unit_if bus();

    f_fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk     (clk),
        .reset   (reset),
        .imem    (bus),
        .npc_f   (npc_f),
        .stall_d (stall_d),
        .pc_f    (pc_f),
        .instr_d (instr_d),
        .pc_d    (pc_d),
        .pc8_d   (pc8_d),
        .valid_d (valid_d)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] bmap [logic [31:0]];
    bit          busy;
    int          dly;
    int          lat;
    logic [31:0] maddr;
    logic [31:0] gaddr;

    function automatic logic is_br(input logic [31:0] w);
        return w[31:28] == 4'hB;
    endfunction

    function automatic logic [31:0] br_tgt(input logic [31:0] w);
        return {{16{w[16]}}, w[15:0]};
    endfunction

    function automatic logic [31:0] word(input logic [31:0] a);
        if (bmap.exists(a)) return bmap[a];
        return {4'h1, a[27:0]};
    endfunction

    assign npc_f = (valid_d && is_br(instr_d)) ? br_tgt(instr_d) : pc_f + 32'd4;

    task automatic cyc(input logic st, input logic g_ok, input logic rs, input logic stray);
        logic gnt_d;
        stall_d          = st;
        reset            = rs;
        bus.imem_gnt     = 1'b0;
        bus.imem_rvalid  = 1'b0;
        bus.imem_rdata   = 32'd0;
        if (busy && dly == 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = word(maddr);
        end else if (stray) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 32'hDEAD_BEEF;
        end
        if (!busy && g_ok && bus.imem_req === 1'b1) begin
            bus.imem_gnt = 1'b1;
            gaddr        = bus.imem_addr;
        end
        gnt_d = bus.imem_gnt;
        @(posedge clk);
        if (busy) begin
            if (dly == 0) busy = 1'b0;
            else dly--;
        end
        if (rs) busy = 1'b0;
        else if (gnt_d) begin
            busy  = 1'b1;
            maddr = gaddr;
            dly   = lat;
        end
        #1;
    endtask

    task automatic do_reset();
        bmap.delete();
        busy = 1'b0;
        lat  = 0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (pc_f !== 32'h3000) begin n_fail++; $display("FAIL reset_pc_f got %h want %h", pc_f, 32'h3000); end
        n_tests++; if ({valid_d, instr_d, pc_d} !== 65'd0) begin n_fail++; $display("FAIL reset_fd got v=%b i=%h p=%h want 0", valid_d, instr_d, pc_d); end
        n_tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3000) begin n_fail++; $display("FAIL reset_req got req=%b addr=%h want 1 3000", bus.imem_req, bus.imem_addr); end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        n_tests++; if (valid_d !== 1'b0) begin n_fail++; $display("FAIL first_wait valid got %b want 0", valid_d); end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (instr_d !== word(32'h3000) || pc_d !== 32'h3000 || pc8_d !== 32'h3008 || pc_f !== 32'h3004 || valid_d !== 1'b1) begin
            n_fail++;
            $display("FAIL first_xfer got i=%h pd=%h p8=%h pf=%h v=%b want %h 3000 3008 3004 1", instr_d, pc_d, pc8_d, pc_f, valid_d, word(32'h3000));
        end
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            n_tests++; if (valid_d !== 1'(i % 2)) begin n_fail++; $display("FAIL steady_valid[%0d] got %b want %b", i, valid_d, 1'(i % 2)); end
        end
    endtask

    task automatic test_gnt_wait();
        do_reset();
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            n_tests++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3004 || valid_d !== 1'b0 || instr_d !== 32'd0) begin
                n_fail++;
                $display("FAIL gnt_wait[%0d] got req=%b addr=%h v=%b i=%h want 1 3004 0 0", i, bus.imem_req, bus.imem_addr, valid_d, instr_d);
            end
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        n_tests++; if (pc_d !== 32'h3004 || instr_d !== word(32'h3004)) begin n_fail++; $display("FAIL gnt_wait_xfer got pd=%h i=%h want 3004 %h", pc_d, instr_d, word(32'h3004)); end
    endtask

    task automatic test_stall_hold();
        do_reset();
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            n_tests++;
            if (pc_d !== 32'h3000 || instr_d !== word(32'h3000) || valid_d !== 1'b1 || pc_f !== 32'h3004) begin
                n_fail++;
                $display("FAIL stall_fd[%0d] got pd=%h i=%h v=%b pf=%h want 3000 %h 1 3004", i, pc_d, instr_d, valid_d, pc_f, word(32'h3000));
            end
            if (i >= 1) begin
                n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_noreq[%0d] got %b want 0", i, bus.imem_req); end
            end
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (pc_d !== 32'h3004 || instr_d !== word(32'h3004) || pc_f !== 32'h3008 || bus.imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release got pd=%h i=%h pf=%h req=%b want 3004 %h 3008 1", pc_d, instr_d, pc_f, bus.imem_req, word(32'h3004));
        end
    endtask

    task automatic branch_prologue();
        do_reset();
        bmap[32'h3004] = {4'hB, 12'h000, 16'h3100};
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_branch();
        bit seen;
        branch_prologue();
        n_tests++; if (pc_d !== 32'h3004 || pc_f !== 32'h3008 || npc_f !== 32'h3100) begin n_fail++; $display("FAIL br_setup got pd=%h pf=%h npc=%h want 3004 3008 3100", pc_d, pc_f, npc_f); end
        lat  = 4;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            if (valid_d === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (!seen || pc_d !== 32'h3008 || instr_d !== word(32'h3008) || pc_f !== 32'h3100 || bus.imem_addr !== 32'h3100) begin
            n_fail++;
            $display("FAIL br_slot got seen=%b pd=%h i=%h pf=%h addr=%h want 1 3008 %h 3100 3100", seen, pc_d, instr_d, pc_f, bus.imem_addr, word(32'h3008));
        end
    endtask

    task automatic test_branch_stall();
        branch_prologue();
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        n_tests++; if (pc_d !== 32'h3004 || pc_f !== 32'h3008) begin n_fail++; $display("FAIL brst_hold got pd=%h pf=%h want 3004 3008", pc_d, pc_f); end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (pc_d !== 32'h3008 || instr_d !== word(32'h3008) || pc_f !== 32'h3100) begin
            n_fail++;
            $display("FAIL brst_xfer got pd=%h i=%h pf=%h want 3008 %h 3100", pc_d, instr_d, pc_f, word(32'h3008));
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp [5];
        int          k;
        exp[0] = 32'h3000; exp[1] = 32'h3004; exp[2] = 32'h3008; exp[3] = 32'hFFFF_FFF8; exp[4] = 32'hFFFF_FFFC;
        do_reset();
        bmap[32'h3004] = {4'hB, 11'h000, 1'b1, 16'hFFF8};
        k = 0;
        for (int c = 0; c < 30 && k < 5; c++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            if (valid_d === 1'b1) begin
                n_tests++;
                if (pc_d !== exp[k] || pc8_d !== exp[k] + 32'd8) begin
                    n_fail++;
                    $display("FAIL wrap[%0d] got pd=%h p8=%h want %h %h", k, pc_d, pc8_d, exp[k], exp[k] + 32'd8);
                end
                k++;
            end
        end
        n_tests++; if (k != 5) begin n_fail++; $display("FAIL wrap_count got %0d want 5", k); end
    endtask

    task automatic test_reset_wait();
        bit seen;
        do_reset();
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        lat = 3;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        n_tests++;
        if (pc_f !== 32'h3000 || valid_d !== 1'b0 || instr_d !== 32'd0 || pc_d !== 32'd0 || bus.imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_wait got pf=%h v=%b i=%h pd=%h req=%b want 3000 0 0 0 1", pc_f, valid_d, instr_d, pc_d, bus.imem_req);
        end
        lat = 0;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        n_tests++; if (valid_d !== 1'b0 || bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL stray_rvalid got v=%b req=%b want 0 1", valid_d, bus.imem_req); end
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            if (valid_d === 1'b1) seen = 1'b1;
        end
        n_tests++; if (!seen || pc_d !== 32'h3000 || instr_d !== word(32'h3000)) begin n_fail++; $display("FAIL rst_first got seen=%b pd=%h i=%h want 1 3000 %h", seen, pc_d, instr_d, word(32'h3000)); end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] prev;
        logic [31:0] w;
        logic [31:0] p_pc_d;
        logic [31:0] p_instr;
        logic        p_valid;
        logic        st;
        int          nx;
        do_reset();
        for (int i = 0; i < 24; i++)
            bmap[32'h3004 + 4 * $urandom_range(0, 254)] = {4'hB, 12'h000, 16'(32'h3000 + 4 * $urandom_range(0, 255))};
        exp_pc = 32'h3000;
        prev   = 32'd0;
        nx     = 0;
        for (int c = 0; c < 800; c++) begin
            st      = ($urandom_range(0, 3) == 0);
            lat     = int'($urandom_range(0, 2));
            p_pc_d  = pc_d;
            p_instr = instr_d;
            p_valid = valid_d;
            cyc(st, $urandom_range(0, 9) < 7, 1'b0, 1'b0);
            if (st) begin
                n_tests++;
                if (pc_d !== p_pc_d || instr_d !== p_instr || valid_d !== p_valid) begin
                    n_fail++;
                    $display("FAIL rnd_stall[%0d] got %h %h %b want %h %h %b", c, pc_d, instr_d, valid_d, p_pc_d, p_instr, p_valid);
                end
            end else if (valid_d === 1'b1) begin
                w = word(exp_pc);
                n_tests++;
                if (pc_d !== exp_pc || instr_d !== w || pc8_d !== exp_pc + 32'd8) begin
                    n_fail++;
                    $display("FAIL rnd_xfer[%0d] got pd=%h i=%h p8=%h want %h %h %h", nx, pc_d, instr_d, pc8_d, exp_pc, w, exp_pc + 32'd8);
                end
                nx++;
                exp_pc = is_br(prev) ? br_tgt(prev) : exp_pc + 32'd4;
                prev   = w;
            end
        end
        n_tests++; if (nx < 50) begin n_fail++; $display("FAIL rnd_progress got %0d transfers want >= 50", nx); end
    endtask

    initial begin
        test_reset();
        test_gnt_wait();
        test_stall_hold();
        test_branch();
        test_branch_stall();
        test_wrap();
        test_reset_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
